// File: rtl/mcs4_pkg.sv
// Shared MCS-4 bus types and opcode constants for the i4004/i4001/i4002 models.
package mcs4;

  typedef enum logic [2:0] {
    CycA1 = 3'd0,
    CycA2 = 3'd1,
    CycA3 = 3'd2,
    CycM1 = 3'd3,
    CycM2 = 3'd4,
    CycX1 = 3'd5,
    CycX2 = 3'd6,
    CycX3 = 3'd7
  } instr_cyc_t;

  // OPA encodings of the I/O and RAM group (OPR = 4'hE); OPA[3] set means a read.
  typedef enum logic [3:0] {
    OpaWrm = 4'h0,
    OpaWmp = 4'h1,
    OpaWrr = 4'h2,
    OpaWpm = 4'h3,
    OpaWr0 = 4'h4,
    OpaWr1 = 4'h5,
    OpaWr2 = 4'h6,
    OpaWr3 = 4'h7,
    OpaSbm = 4'h8,
    OpaRdm = 4'h9,
    OpaRdr = 4'hA,
    OpaAdm = 4'hB,
    OpaRd0 = 4'hC,
    OpaRd1 = 4'hD,
    OpaRd2 = 4'hE,
    OpaRd3 = 4'hF
  } ioram_opa_t;

  typedef logic [3:0]  char_t;
  typedef logic [7:0]  byte_t;
  typedef logic [11:0] addr_t;

  localparam char_t OPR_IO      = 4'hE;
  localparam char_t OPR_FIM_SRC = 4'h2;

  function automatic logic is_src(input char_t opr, input char_t opa);
    return (opr == OPR_FIM_SRC) && opa[0];
  endfunction

  function automatic logic is_io_read(input char_t opr, input char_t opa);
    return (opr == OPR_IO) && opa[3];
  endfunction

  function automatic logic is_io_write(input char_t opr, input char_t opa);
    return (opr == OPR_IO) && !opa[3];
  endfunction

endpackage

// File: rtl/mcs4_cyc_gen.sv
// 8-phase MCS-4 instruction-cycle counter with sync decode; resets into X3 so A1 follows.
module mcs4_cyc_gen
  import mcs4::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] icyc,
  output logic       sync
);

  instr_cyc_t icyc_q, icyc_d;

  always_comb begin
    icyc_d = CycA1;
    if (icyc_q != CycX3) begin
      icyc_d = instr_cyc_t'(icyc_q + 3'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      icyc_q <= CycX3;
    end else begin
      icyc_q <= icyc_d;
    end
  end

  assign icyc = icyc_q;
  assign sync = (icyc_q == CycX3);

endmodule

// File: rtl/i4004_bus_ctrl.sv
// CPU-side MCS-4 bus master: address drive, OPR/OPA capture, CM-ROM strobe and X2/X3 operands.
module i4004_bus_ctrl
  import mcs4::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        sync,
  output logic        cl_rom,
  output logic        cm_rom,
  input  logic [3:0]  dbus_in,
  output logic [3:0]  dbus_out,
  input  logic [11:0] pc,
  input  logic [7:0]  src_data,
  input  logic [3:0]  acc,
  output logic [7:0]  instr,
  output logic        instr_valid,
  output logic [3:0]  io_rdata,
  output logic        io_rdata_valid
);

  logic [2:0] icyc_raw;
  instr_cyc_t icyc;

  mcs4_cyc_gen u_cyc_gen (
    .clk  (clk),
    .rst  (rst),
    .icyc (icyc_raw),
    .sync (sync)
  );

  assign icyc = instr_cyc_t'(icyc_raw);

  addr_t addr_q;
  char_t opr_q, opa_q, io_rdata_q;
  logic  cl_rom_q;
  logic  op_io, op_wr, op_rd, op_src;

  always_comb begin
    op_io  = (opr_q == OPR_IO);
    op_wr  = is_io_write(opr_q, opa_q);
    op_rd  = is_io_read(opr_q, opa_q);
    op_src = is_src(opr_q, opa_q);
  end

  // cl_rom is a plain delayed copy of rst, so it is deliberately outside the reset branch.
  always_ff @(posedge clk) begin
    cl_rom_q <= rst;
    if (rst) begin
      addr_q     <= '0;
      opr_q      <= '0;
      opa_q      <= '0;
      io_rdata_q <= '0;
    end else begin
      if (icyc == CycX3) addr_q <= pc;
      if (icyc == CycM1) opr_q <= dbus_in;
      if (icyc == CycM2) opa_q <= dbus_in;
      if (icyc == CycX2 && op_rd) io_rdata_q <= dbus_in;
    end
  end

  always_comb begin
    dbus_out       = '0;
    cm_rom         = 1'b0;
    instr_valid    = 1'b0;
    io_rdata_valid = 1'b0;
    case (icyc)
      CycA1: dbus_out = addr_q[3:0];
      CycA2: dbus_out = addr_q[7:4];
      CycA3: dbus_out = addr_q[11:8];
      CycM1: ;
      // OPR was latched at the end of M1, so the strobe decode is already valid here.
      CycM2: cm_rom = op_io;
      CycX1: instr_valid = 1'b1;
      CycX2: begin
        if (op_wr) begin
          dbus_out = acc;
        end else if (op_src) begin
          dbus_out = src_data[7:4];
          cm_rom   = 1'b1;
        end
      end
      CycX3: begin
        if (op_src) dbus_out = src_data[3:0];
        io_rdata_valid = op_rd;
      end
    endcase
  end

  assign instr    = {opr_q, opa_q};
  assign io_rdata = io_rdata_q;
  assign cl_rom   = cl_rom_q;

endmodule

// File: tb/tb_i4004_bus_ctrl.sv
// Directed scoreboard bench for i4004_bus_ctrl: one expectation per bus phase.
module tb_i4004_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sync, cl_rom, cm_rom;
  logic [3:0]  dbus_in, dbus_out, acc, io_rdata;
  logic [11:0] pc;
  logic [7:0]  src_data, instr;
  logic        instr_valid, io_rdata_valid;

  i4004_bus_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .sync           (sync),
    .cl_rom         (cl_rom),
    .cm_rom         (cm_rom),
    .dbus_in        (dbus_in),
    .dbus_out       (dbus_out),
    .pc             (pc),
    .src_data       (src_data),
    .acc            (acc),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .io_rdata       (io_rdata),
    .io_rdata_valid (io_rdata_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] dbus;
    logic       cm;
    logic       sync;
    logic       iv;
    logic       iov;
    logic       cl;
    logic       ci;
    logic [7:0] instr;
    logic [3:0] iord;
  } exp_t;

  exp_t       sb[$];
  int         n_assert = 0;
  int         n_fail = 0;
  logic [3:0] io_exp;
  logic       prev_rst;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Drive one bus phase, queue its expectation, compare mid-cycle, advance past the edge.
  task automatic phase(input logic r, input logic [3:0] din, input exp_t e_in);
    exp_t e, x;
    e      = e_in;
    e.cl   = prev_rst;
    e.iord = io_exp;
    rst     = r;
    dbus_in = din;
    sb.push_back(e);
    @(negedge clk);
    x = sb.pop_front();
    chk({x.tag, " dbus_out"}, 12'(dbus_out), 12'(x.dbus));
    chk({x.tag, " cm_rom"}, 12'(cm_rom), 12'(x.cm));
    chk({x.tag, " sync"}, 12'(sync), 12'(x.sync));
    chk({x.tag, " instr_valid"}, 12'(instr_valid), 12'(x.iv));
    chk({x.tag, " io_rdata_valid"}, 12'(io_rdata_valid), 12'(x.iov));
    chk({x.tag, " cl_rom"}, 12'(cl_rom), 12'(x.cl));
    chk({x.tag, " io_rdata"}, 12'(io_rdata), 12'(x.iord));
    if (x.ci) chk({x.tag, " instr"}, 12'(instr), 12'(x.instr));
    @(posedge clk);
    #1;
    prev_rst = r;
    if (r) io_exp = 4'h0;
  endtask

  // One full instruction cycle from A1; abort_at >= 0 raises rst in that phase.
  task automatic instr_cycle(input string tag, input logic [11:0] a, input logic [7:0] w,
                             input logic [3:0] acc_v, input logic [7:0] src_v,
                             input logic [3:0] x2_in, input logic [11:0] next_pc,
                             input int abort_at);
    logic [3:0] opr, opa, din;
    logic       io, rd, wr, sr;
    exp_t       e;
    opr = w[7:4];
    opa = w[3:0];
    io  = (opr == 4'hE);
    rd  = io && opa[3];
    wr  = io && !opa[3];
    sr  = (opr == 4'h2) && opa[0];
    acc      = acc_v;
    src_data = src_v;
    pc       = next_pc;
    for (int p = 0; p < 8; p++) begin
      e.tag   = $sformatf("%s.%0d", tag, p);
      e.dbus  = 4'h0;
      e.cm    = 1'b0;
      e.sync  = (p == 7);
      e.iv    = (p == 5);
      e.ci    = (p == 5);
      e.iov   = 1'b0;
      e.instr = w;
      din     = 4'h0;
      case (p)
        0: e.dbus = a[3:0];
        1: e.dbus = a[7:4];
        2: e.dbus = a[11:8];
        3: din = opr;
        4: begin
          din  = opa;
          e.cm = io;
        end
        6: begin
          din = x2_in;
          if (wr) begin
            e.dbus = acc_v;
          end else if (sr) begin
            e.dbus = src_v[7:4];
            e.cm   = 1'b1;
          end
        end
        7: begin
          if (sr) e.dbus = src_v[3:0];
          e.iov = rd;
          if (rd) io_exp = x2_in;
        end
        default: ;
      endcase
      if (p == abort_at) begin
        phase(1'b1, din, e);
        e.tag   = {tag, ".rstX3"};
        e.dbus  = 4'h0;
        e.cm    = 1'b0;
        e.sync  = 1'b1;
        e.iv    = 1'b0;
        e.iov   = 1'b0;
        e.ci    = 1'b1;
        e.instr = 8'h00;
        phase(1'b0, 4'h0, e);
        return;
      end
      phase(1'b0, din, e);
    end
  endtask

  initial begin
    exp_t e0;
    rst      = 1'b1;
    dbus_in  = 4'h0;
    pc       = 12'h123;
    acc      = 4'h0;
    src_data = 8'h00;
    prev_rst = 1'b1;
    io_exp   = 4'h0;
    repeat (3) @(posedge clk);
    #1;

    e0.tag   = "reset.X3";
    e0.dbus  = 4'h0;
    e0.cm    = 1'b0;
    e0.sync  = 1'b1;
    e0.iv    = 1'b0;
    e0.iov   = 1'b0;
    e0.ci    = 1'b1;
    e0.instr = 8'h00;
    phase(1'b0, 4'h0, e0);

    instr_cycle("wrr", 12'h123, 8'hE2, 4'h5, 8'h00, 4'h0, 12'h124, -1);
    instr_cycle("src", 12'h124, 8'h21, 4'h0, 8'h4A, 4'h0, 12'h125, -1);
    instr_cycle("rdr", 12'h125, 8'hEA, 4'h0, 8'h00, 4'h9, 12'hFFE, -1);
    instr_cycle("nop0", 12'hFFE, 8'h00, 4'h7, 8'hC3, 4'h0, 12'hFFF, -1);
    instr_cycle("nop1", 12'hFFF, 8'h00, 4'h7, 8'hC3, 4'h0, 12'h000, -1);
    instr_cycle("nop2", 12'h000, 8'h00, 4'h7, 8'hC3, 4'h0, 12'h001, -1);
    instr_cycle("nop3", 12'h001, 8'h00, 4'h7, 8'hC3, 4'h0, 12'h002, -1);
    instr_cycle("abort", 12'h002, 8'hE2, 4'h5, 8'h00, 4'h0, 12'h3C5, 3);
    instr_cycle("post", 12'h3C5, 8'h00, 4'h5, 8'h00, 4'h0, 12'h3C6, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
